count_bcd_converter: RTL

Sequential binary-to-BCD converter consuming the 20-bit free-running count (0..999999) from the GPIO-speed counter stage. It converts one sampled count into six packed BCD digits using an iterative shift-add-3 (double-dabble) datapath, one bit per clock. The start/busy/done handshake lets a downstream display or GPIO driver request a snapshot at its own rate.

---
 rtl/count_bcd_converter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/count_bcd_converter.sv
// rtl/count_bcd_converter.sv - sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake
module count_bcd_converter #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6,
  parameter int MAXVAL = 999999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAXVAL);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [BW-1:0]    ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;

  logic [BW-1:0]   corr;
  logic [BW-1:0]   shifted;

  // Add-3 correction on every digit that would reach 10 or more after doubling,
  // then shift the binary MSB into scratch bit 0. The carry out of the top
  // digit falls off; it can only occur for saturated inputs.
  always_comb begin
    corr = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = (corr << 1) | BW'(bin_q[WIDTH-1]);
  end

  // Next-state and datapath control for IDLE -> SHIFT x WIDTH -> DONE -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = bin;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = (bin > MAX_V);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        bin_d     = bin_q << 1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bcd_d      = ovf_pend_q ? ALL_NINES : shifted;
          overflow_d = ovf_pend_q;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      scratch_q  <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule
